// File: rtl/lsu.sv
// Load/store unit: converts an address plus funct3 into a single word-aligned data-memory access,
// then waits for the acknowledge (or a timeout) and returns extended load data to writeback.
module lsu #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        stall,
  output logic        done,
  output logic        err,
  output logic [31:0] data_out,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_wstrb,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic [7:0] LP_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      r_state;
  state_t      w_next;
  logic        r_load;
  logic [2:0]  r_f3;
  logic [1:0]  r_lane;
  logic [7:0]  r_cnt;
  logic        r_done;
  logic        r_err;
  logic        r_req;
  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_data;
  logic [3:0]  r_strb;

  logic        w_op;
  logic        w_op_ok;
  logic        w_f3_ok;
  logic        w_aligned;
  logic        w_ok;
  logic        w_timeout;
  logic [3:0]  w_strb;
  logic [31:0] w_wdata;
  logic [31:0] w_load;

  function automatic logic [3:0] lane_strb(input logic [1:0] size, input logic [1:0] lane);
    logic [3:0] s;
    case (size)
      2'd0:    s = 4'b0001 << lane;
      2'd1:    s = 4'b0011 << lane;
      default: s = 4'b1111;
    endcase
    return s;
  endfunction

  function automatic logic [31:0] load_ext(input logic [31:0] rdata, input logic [2:0] f3,
                                           input logic [1:0] lane);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] v;
    b = rdata[{lane, 3'b000} +: 8];
    h = lane[1] ? rdata[31:16] : rdata[15:0];
    case (f3)
      3'd0:    v = {{24{b[7]}}, b};
      3'd1:    v = {{16{h[15]}}, h};
      3'd4:    v = {24'd0, b};
      3'd5:    v = {16'd0, h};
      default: v = rdata;
    endcase
    return v;
  endfunction

  assign w_op      = mem_read | mem_write;
  assign w_op_ok   = mem_read ^ mem_write;
  assign w_ok      = w_op_ok & w_f3_ok & w_aligned;
  assign w_timeout = (r_cnt == LP_LAST);
  assign w_load    = load_ext(dmem_rdata, r_f3, r_lane);

  // Request legality: funct3 range per operation and natural alignment of the access size
  always_comb begin
    w_f3_ok   = 1'b0;
    w_aligned = 1'b1;
    case (funct3)
      3'd0, 3'd1, 3'd2: w_f3_ok = 1'b1;
      3'd4, 3'd5:       w_f3_ok = mem_read;
      default:          w_f3_ok = 1'b0;
    endcase
    case (funct3[1:0])
      2'd1:    w_aligned = ~addr[0];
      2'd2:    w_aligned = (addr[1:0] == 2'b00);
      default: w_aligned = 1'b1;
    endcase
  end

  // Store byte lanes and replicated write data; reads drive no strobes
  always_comb begin
    w_strb  = 4'b0000;
    w_wdata = 32'd0;
    if (mem_write) begin
      w_strb = lane_strb(funct3[1:0], addr[1:0]);
      case (funct3[1:0])
        2'd0:    w_wdata = {4{store_data[7:0]}};
        2'd1:    w_wdata = {2{store_data[15:0]}};
        default: w_wdata = store_data;
      endcase
    end else begin
      w_strb  = 4'b0000;
      w_wdata = 32'd0;
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic; an ack on the timeout cycle takes priority over the abort
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (start && w_op) begin
          w_next = w_ok ? ACCESS : RESP;
        end else begin
          w_next = IDLE;
        end
      end
      ACCESS: begin
        if (dmem_ack || w_timeout) begin
          w_next = RESP;
        end else begin
          w_next = ACCESS;
        end
      end
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Datapath and registered outputs: latch request, hold bus signals, capture load result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_load  <= 1'b0;
      r_f3    <= 3'd0;
      r_lane  <= 2'd0;
      r_cnt   <= 8'd0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_req   <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= 32'd0;
      r_wdata <= 32'd0;
      r_data  <= 32'd0;
      r_strb  <= 4'd0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          r_err <= 1'b0;
          r_cnt <= 8'd0;
          if (start && w_op) begin
            r_load <= mem_read;
            r_f3   <= funct3;
            r_lane <= addr[1:0];
            if (w_ok) begin
              r_req   <= 1'b1;
              r_we    <= mem_write;
              r_addr  <= {addr[31:2], 2'b00};
              r_strb  <= w_strb;
              r_wdata <= w_wdata;
            end else begin
              r_done <= 1'b1;
              r_err  <= 1'b1;
            end
          end
        end
        ACCESS: begin
          if (dmem_ack) begin
            r_req  <= 1'b0;
            r_done <= 1'b1;
            r_err  <= 1'b0;
            if (r_load) begin
              r_data <= w_load;
            end
          end else if (w_timeout) begin
            r_req  <= 1'b0;
            r_done <= 1'b1;
            r_err  <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        RESP: begin
          r_err <= 1'b0;
          r_cnt <= 8'd0;
        end
        default: begin
          r_req <= 1'b0;
          r_err <= 1'b0;
        end
      endcase
    end
  end

  assign stall      = ((r_state == IDLE) && start && w_op) || (r_state == ACCESS);
  assign done       = r_done;
  assign err        = r_err;
  assign data_out   = r_data;
  assign dmem_req   = r_req;
  assign dmem_we    = r_we;
  assign dmem_addr  = r_addr;
  assign dmem_wstrb = r_strb;
  assign dmem_wdata = r_wdata;

endmodule

// File: tb/tb_lsu.sv
// Scoreboard bench for lsu: a driver issues random and directed accesses and plays the memory,
// pushing expected bus and response records; a negedge monitor pops and compares them.
module tb_lsu;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        mem_read;
  logic        mem_write;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic        stall;
  logic        done;
  logic        err;
  logic [31:0] data_out;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_wstrb;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;

  lsu #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .mem_read(mem_read), .mem_write(mem_write),
    .funct3(funct3), .addr(addr), .store_data(store_data), .stall(stall), .done(done),
    .err(err), .data_out(data_out), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wstrb(dmem_wstrb), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack)
  );

  always #5 clk = ~clk;

  int unsigned pcnt = 0;
  always @(posedge clk) pcnt <= pcnt + 1;

  typedef struct {
    logic        we;
    logic [31:0] a;
    logic [3:0]  s;
    logic [31:0] d;
  } bus_t;

  typedef struct {
    logic        err;
    logic [31:0] data;
    int unsigned at;
  } rsp_t;

  bus_t        bq[$];
  rsp_t        rq[$];
  bus_t        mb;
  rsp_t        mr;
  logic [31:0] m_data;
  logic        prev_req = 1'b0;
  int          checks = 0;
  int          fails = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // Monitor: compare bus fields when a request appears, and the response when done pulses
  always @(negedge clk) begin
    if (!rst) begin
      if (dmem_req && !prev_req) begin
        if (bq.size() == 0) begin
          chk("unexpected_req", {31'd0, dmem_req}, 32'd0);
        end else begin
          mb = bq.pop_front();
          chk("bus_we", {31'd0, dmem_we}, {31'd0, mb.we});
          chk("bus_addr", dmem_addr, mb.a);
          chk("bus_wstrb", {28'd0, dmem_wstrb}, {28'd0, mb.s});
          if (mb.we) chk("bus_wdata", dmem_wdata, mb.d);
        end
      end
      if (done) begin
        if (rq.size() == 0) begin
          chk("unexpected_done", {31'd0, done}, 32'd0);
        end else begin
          mr = rq.pop_front();
          chk("rsp_err", {31'd0, err}, {31'd0, mr.err});
          chk("rsp_data", data_out, mr.data);
          chk("rsp_cycle", pcnt, mr.at);
          chk("req_dropped", {31'd0, dmem_req}, 32'd0);
        end
      end
    end
    prev_req <= dmem_req;
  end

  task automatic txn(input logic rd, input logic wr, input logic [2:0] f3, input logic [31:0] a,
                     input logic [31:0] sd, input int dly, input logic [31:0] rdat, input bit junk);
    bit          legal;
    bit          to;
    int          sz;
    int          m;
    int          nw;
    logic [3:0]  strb;
    logic [31:0] wd;
    logic [31:0] ld;
    logic [63:0] mask;
    bus_t        b;
    rsp_t        r;
    @(negedge clk);
    sz    = 1 << (int'(f3) % 4);
    legal = (rd != wr) && (rd ? (f3 != 3'd3 && f3 < 3'd6) : (f3 < 3'd3)) && ((a % sz) == 0);
    to    = legal && (dly > TO);
    m     = 1;
    if (rd || wr) begin
      if (legal) begin
        m    = to ? TO + 1 : dly + 1;
        strb = wr ? 4'(((1 << sz) - 1) << (a % 4)) : 4'd0;
        for (int i = 0; i < 4; i++) wd[8*i +: 8] = sd[8*(i % sz) +: 8];
        b.we = wr; b.a = a & ~32'd3; b.s = strb; b.d = wd;
        bq.push_back(b);
        if (rd && !to) begin
          mask = (64'd1 << (8 * sz)) - 64'd1;
          ld   = (rdat >> (8 * (a % 4))) & mask[31:0];
          if (f3 < 3'd4 && sz < 4 && ld[8*sz-1]) ld = ld | ~mask[31:0];
          m_data = ld;
        end
      end
      r.err = !legal || to; r.data = m_data; r.at = pcnt + 32'(m);
      rq.push_back(r);
    end
    start = 1'b1; mem_read = rd; mem_write = wr; funct3 = f3; addr = a; store_data = sd;
    dmem_ack = 1'b0;
    #1 chk("stall_issue", {31'd0, stall}, {31'd0, rd | wr});
    nw = (rd || wr) ? m : 1;
    for (int n = 1; n <= nw; n++) begin
      @(negedge clk);
      dmem_ack   = 1'b0;
      dmem_rdata = $urandom;
      if (junk && (rd || wr)) begin
        start = 1'($urandom); mem_read = 1'($urandom); mem_write = 1'($urandom);
        funct3 = 3'($urandom); addr = $urandom;
      end else begin
        start = 1'b0;
      end
      if (legal && !to && n == dly) begin
        dmem_ack   = 1'b1;
        dmem_rdata = rdat;
      end
      #1 chk("stall_busy", {31'd0, stall}, {31'd0, 1'(legal && n < m)});
    end
    start = 1'b0; dmem_ack = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; mem_read = 1'b0; mem_write = 1'b0; funct3 = 3'd0;
    addr = 32'd0; store_data = 32'd0; dmem_rdata = 32'd0; dmem_ack = 1'b0; m_data = 32'd0;
    repeat (3) @(negedge clk);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_done", {30'd0, done, err}, 32'd0);
    chk("rst_req", {30'd0, dmem_req, dmem_we}, 32'd0);
    chk("rst_addr", dmem_addr, 32'd0);
    chk("rst_strb_wdata", dmem_wdata | {28'd0, dmem_wstrb}, 32'd0);
    chk("rst_data", data_out, 32'd0);
    rst = 1'b0;

    txn(1'b1, 1'b0, 3'd2, 32'h100, 32'd0, 3, 32'hDEADBEEF, 1'b0);
    chk("lw_const", data_out, 32'hDEADBEEF);
    txn(1'b1, 1'b0, 3'd0, 32'h103, 32'd0, 2, 32'h80FF_0000, 1'b0);
    chk("lb_const", data_out, 32'hFFFFFF80);
    txn(1'b1, 1'b0, 3'd4, 32'h103, 32'd0, 1, 32'h80FF_0000, 1'b0);
    chk("lbu_const", data_out, 32'h00000080);
    txn(1'b0, 1'b1, 3'd1, 32'h202, 32'h1234ABCD, 1, 32'd0, 1'b0);
    txn(1'b1, 1'b0, 3'd2, 32'h101, 32'd0, 1, 32'h11111111, 1'b0);
    chk("misaligned_hold", data_out, 32'h00000080);
    txn(1'b0, 1'b1, 3'd2, 32'h300, 32'hCAFEF00D, 6, 32'd0, 1'b0);
    txn(1'b0, 1'b1, 3'd2, 32'h304, 32'h0BADF00D, TO, 32'd0, 1'b0);
    txn(1'b1, 1'b1, 3'd2, 32'h400, 32'd0, 1, 32'd0, 1'b0);
    txn(1'b1, 1'b0, 3'd3, 32'h400, 32'd0, 1, 32'd0, 1'b0);
    txn(1'b1, 1'b0, 3'd2, 32'h404, 32'd0, 6, 32'h5555AAAA, 1'b0);
    chk("timeout_hold", data_out, 32'h00000080);

    // reset while the bus request is outstanding
    txn(1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 1, 32'd0, 1'b0);
    @(negedge clk);
    bq.push_back('{we: 1'b0, a: 32'h40, s: 4'd0, d: 32'd0});
    rq.push_back('{err: 1'b0, data: 32'd0, at: pcnt + 32'd9});
    start = 1'b1; mem_read = 1'b1; mem_write = 1'b0; funct3 = 3'd2; addr = 32'h40;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_mid_req", {31'd0, dmem_req}, 32'd0);
    chk("rst_mid_stall", {31'd0, stall}, 32'd0);
    void'(rq.pop_back());
    m_data = 32'd0;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_data", data_out, 32'd0);
    txn(1'b1, 1'b0, 3'd2, 32'h44, 32'd0, 2, 32'h13572468, 1'b0);
    chk("after_rst_lw", data_out, 32'h13572468);

    for (int t = 0; t < 200; t++) begin
      logic rd, wr;
      int   sel;
      sel = $urandom_range(0, 19);
      rd  = (sel < 9) || (sel == 18);
      wr  = (sel >= 9 && sel < 18) || (sel == 18);
      txn(rd, wr, 3'($urandom), $urandom, $urandom, $urandom_range(1, 6), $urandom,
          1'($urandom));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (4) @(negedge clk);
    chk("rsp_queue_empty", 32'(rq.size()), 32'd0);
    chk("bus_queue_empty", 32'(bq.size()), 32'd0);
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
